// File: rtl/pulse_sequencer.sv
// pulse_sequencer: bank of independent delayed one-shot pulse channels with retrigger and status strobes.
// Optional max-on fault limit is enabled by defining SEQ_MAX_ON_EN.
module pulse_sequencer #(
  parameter int unsigned      CHANNELS = 4,
  parameter int unsigned      WIDTH    = 24,
  parameter logic [WIDTH-1:0] MAX_ON   = WIDTH'(24'hFFFFFF)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [CHANNELS-1:0]       trigger,
  input  logic [CHANNELS-1:0]       retrig,
  input  logic [CHANNELS*WIDTH-1:0] delay,
  input  logic [CHANNELS*WIDTH-1:0] duration,
  input  logic [CHANNELS-1:0]       fault_clr,
  output logic [CHANNELS-1:0]       out,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS-1:0]       done,
  output logic [CHANNELS-1:0]       overrun,
  output logic [CHANNELS-1:0]       fault
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

`ifndef SEQ_MAX_ON_EN
  logic unused_max_on;
  assign unused_max_on = ^{fault_clr, MAX_ON};
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] dly_q;
    logic [WIDTH-1:0] dur_q;
    logic [WIDTH-1:0] dly_in;
    logic [WIDTH-1:0] dur_in;
    logic             out_q;
    logic             busy_q;
    logic             done_q;
    logic             ovr_q;
    logic             fault_q;

    assign dly_in = delay[i*WIDTH +: WIDTH];
    assign dur_in = duration[i*WIDTH +: WIDTH];

`ifndef SEQ_MAX_ON_EN
    assign fault_q = 1'b0;
`endif

    // Per-channel sequencer; counter runs 0..delay in DELAY and 1..duration in ACTIVE.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state  <= IDLE;
        cnt    <= '0;
        dly_q  <= '0;
        dur_q  <= '0;
        out_q  <= 1'b0;
        busy_q <= 1'b0;
        done_q <= 1'b0;
        ovr_q  <= 1'b0;
`ifdef SEQ_MAX_ON_EN
        fault_q <= 1'b0;
`endif
      end else begin
        done_q <= 1'b0;
        ovr_q  <= 1'b0;
`ifdef SEQ_MAX_ON_EN
        // Placed before the FSM so a coincident fault set takes priority.
        if (fault_clr[i]) fault_q <= 1'b0;
`endif
        case (state)
          IDLE: begin
            if (trigger[i]) begin
              if (fault_q) begin
                ovr_q <= 1'b1;
              end else begin
                dly_q  <= dly_in;
                dur_q  <= dur_in;
                cnt    <= '0;
                state  <= DELAY;
                busy_q <= 1'b1;
              end
            end
          end
          DELAY: begin
            if (trigger[i] && retrig[i]) begin
              dly_q <= dly_in;
              dur_q <= dur_in;
              cnt   <= '0;
            end else begin
              ovr_q <= trigger[i];
              if (cnt == dly_q) begin
                if (dur_q == '0) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                end else begin
                  state <= ACTIVE;
                  out_q <= 1'b1;
                  cnt   <= WIDTH'(1);
                end
              end else begin
                cnt <= cnt + WIDTH'(1);
              end
            end
          end
          ACTIVE: begin
            if (trigger[i] && retrig[i]) begin
              dly_q <= dly_in;
              dur_q <= dur_in;
              cnt   <= '0;
              state <= DELAY;
              out_q <= 1'b0;
            end else begin
              ovr_q <= trigger[i];
              if (cnt == dur_q) begin
                state  <= IDLE;
                out_q  <= 1'b0;
                busy_q <= 1'b0;
                done_q <= 1'b1;
`ifdef SEQ_MAX_ON_EN
              end else if (cnt == MAX_ON) begin
                state   <= IDLE;
                out_q   <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                fault_q <= 1'b1;
`endif
              end else begin
                cnt <= cnt + WIDTH'(1);
              end
            end
          end
          default: begin
            state  <= IDLE;
            out_q  <= 1'b0;
            busy_q <= 1'b0;
          end
        endcase
      end
    end

    assign out[i]     = out_q;
    assign busy[i]    = busy_q;
    assign done[i]    = done_q;
    assign overrun[i] = ovr_q;
    assign fault[i]   = fault_q;
  end

endmodule

// File: tb/tb_pulse_sequencer.sv
// tb_pulse_sequencer: directed scenarios plus random traffic against a timestamp-based channel model.
module tb_pulse_sequencer;
  localparam int unsigned CH = 4;
  localparam int unsigned W  = 24;
  localparam logic [W-1:0] MAXON = W'(4);
`ifdef SEQ_MAX_ON_EN
  localparam bit MAXON_EN = 1'b1;
`else
  localparam bit MAXON_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset_n;
  logic [CH-1:0]   trigger, retrig, fault_clr;
  logic [CH*W-1:0] delay, duration;
  logic [CH-1:0]   out, busy, done, overrun, fault;

  int n_tests = 0;
  int n_fail  = 0;

  pulse_sequencer #(.CHANNELS(CH), .WIDTH(W), .MAX_ON(MAXON)) dut (
    .clk(clk), .reset_n(reset_n), .trigger(trigger), .retrig(retrig),
    .delay(delay), .duration(duration), .fault_clr(fault_clr),
    .out(out), .busy(busy), .done(done), .overrun(overrun), .fault(fault)
  );

  always #5 clk = ~clk;

  // Model: each accepted trigger at edge n schedules rise at n+d+1 and end at n+d+1+width.
  longint  cyc = 0;
  bit      m_act [CH];
  bit      m_cap [CH];
  longint  m_rise[CH];
  longint  m_end [CH];
  logic [CH-1:0] m_done = '0, m_ovr = '0, m_fault = '0;

  task automatic model_clear();
    for (int c = 0; c < CH; c++) begin
      m_act[c] = 1'b0; m_cap[c] = 1'b0; m_rise[c] = 0; m_end[c] = 0;
    end
    m_done = '0; m_ovr = '0; m_fault = '0;
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk);
      cyc++;
      if (!reset_n) model_clear();
      else begin
        for (int c = 0; c < CH; c++) begin
          bit acc, set_f;
          longint d, u, eff;
          acc = 1'b0; set_f = 1'b0;
          m_done[c] = 1'b0; m_ovr[c] = 1'b0;
          if (trigger[c]) begin
            if (m_act[c]) begin
              if (retrig[c]) acc = 1'b1; else m_ovr[c] = 1'b1;
            end else if (m_fault[c]) m_ovr[c] = 1'b1;
            else acc = 1'b1;
          end
          if (!acc && m_act[c] && cyc == m_end[c]) begin
            m_act[c] = 1'b0; m_done[c] = 1'b1; set_f = m_cap[c];
          end
          if (fault_clr[c] && MAXON_EN) m_fault[c] = 1'b0;
          if (set_f) m_fault[c] = 1'b1;
          if (acc) begin
            d = longint'(delay[c*W +: W]);
            u = longint'(duration[c*W +: W]);
            m_cap[c] = MAXON_EN && (u > longint'(MAXON));
            eff = m_cap[c] ? longint'(MAXON) : u;
            m_rise[c] = cyc + d + 1;
            m_end[c]  = cyc + d + 1 + eff;
            m_act[c]  = 1'b1;
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge reset_n);
    model_clear();
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare every cycle, away from the active edge.
  initial forever begin
    logic [CH-1:0] e_out, e_busy;
    @(negedge clk);
    for (int c = 0; c < CH; c++) begin
      e_busy[c] = m_act[c];
      e_out[c]  = m_act[c] && (cyc >= m_rise[c]);
    end
    chk("cmp_out",     32'(out),     32'(e_out));
    chk("cmp_busy",    32'(busy),    32'(e_busy));
    chk("cmp_done",    32'(done),    32'(m_done));
    chk("cmp_overrun", 32'(overrun), 32'(m_ovr));
    chk("cmp_fault",   32'(fault),   32'(m_fault));
  end

  task automatic set_ch(input int ch, input int d, input int u);
    delay[ch*W +: W]    = W'(d);
    duration[ch*W +: W] = W'(u);
  endtask

  // Bit k of each mask refers to the cycle after edge E_k; trig_at bit k drives trigger into E_k.
  task automatic run_seq(input string name, input int ch, input int n, input logic [31:0] trig_at,
                         input int d0, input int u0, input int d1, input int u1,
                         input logic [31:0] e_out, input logic [31:0] e_busy,
                         input logic [31:0] e_done, input logic [31:0] e_ovr);
    set_ch(ch, d0, u0);
    trigger[ch] = trig_at[0];
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (trig_at[k+1]) set_ch(ch, d1, u1);
      else set_ch(ch, int'($urandom_range(0, 9)), int'($urandom_range(0, 9)));
      trigger[ch] = trig_at[k+1];
      chk({name, "_out"},  32'(out[ch]),     32'(e_out[k]));
      chk({name, "_busy"}, 32'(busy[ch]),    32'(e_busy[k]));
      chk({name, "_done"}, 32'(done[ch]),    32'(e_done[k]));
      chk({name, "_ovr"},  32'(overrun[ch]), 32'(e_ovr[k]));
    end
    trigger[ch] = 1'b0;
  endtask

  task automatic idle(input int n);
    trigger = '0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; trigger = '0; retrig = '0; fault_clr = '0;
    delay = '0; duration = '0;
    repeat (3) @(negedge clk);
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_ovr", 32'(overrun), 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    reset_n = 1'b1;

    run_seq("s1", 0, 11, 32'h1, 3, 5, 3, 5, 32'h1F0, 32'h1FF, 32'h200, 32'h0);
    idle(3);
    run_seq("zero", 1, 3, 32'h1, 0, 0, 0, 0, 32'h0, 32'h1, 32'h2, 32'h0);
    idle(3);
    retrig[2] = 1'b0;
    run_seq("ovr", 2, 10, 32'h5, 4, 3, 4, 3, 32'hE0, 32'hFF, 32'h100, 32'h4);
    idle(3);
    retrig[2] = 1'b1;
    run_seq("retrig", 2, 13, 32'h5, 5, 5, 1, 2, 32'h30, 32'h3F, 32'h40, 32'h0);
    retrig[2] = 1'b0;
    idle(3);
    run_seq("b2b", 3, 7, 32'h9, 0, 1, 0, 1, 32'h12, 32'h1B, 32'h24, 32'h0);
    idle(3);

    // Asynchronous reset while every channel is in ACTIVE.
    for (int c = 0; c < CH; c++) set_ch(c, 1, 20);
    trigger = '1;
    @(negedge clk);
    trigger = '0;
    repeat (4) @(negedge clk);
    chk("pre_rst_out", 32'(out), 32'hF);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_out", 32'(out), 32'h0);
    chk("async_rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    run_seq("s1b", 0, 11, 32'h1, 3, 5, 3, 5, 32'h1F0, 32'h1FF, 32'h200, 32'h0);
    idle(3);

`ifdef SEQ_MAX_ON_EN
    run_seq("maxon", 0, 7, 32'h1, 0, 10, 0, 10, 32'h1E, 32'h1F, 32'h20, 32'h0);
    chk("fault_set", 32'(fault[0]), 32'h1);
    run_seq("fault_ign", 0, 2, 32'h1, 2, 2, 2, 2, 32'h0, 32'h0, 32'h0, 32'h1);
    fault_clr[0] = 1'b1;
    @(negedge clk);
    fault_clr[0] = 1'b0;
    @(negedge clk);
    chk("fault_clr", 32'(fault[0]), 32'h0);
    run_seq("after_clr", 0, 8, 32'h1, 3, 2, 3, 2, 32'h30, 32'h3F, 32'h40, 32'h0);
    idle(3);
`endif

    // Random traffic, checked only by the per-cycle model compare.
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < CH; c++) begin
        trigger[c]   = ($urandom_range(0, 4) == 0);
        retrig[c]    = ($urandom_range(0, 1) == 0);
        fault_clr[c] = ($urandom_range(0, 15) == 0);
        set_ch(c, int'($urandom_range(0, 6)), int'($urandom_range(0, 7)));
      end
      @(negedge clk);
    end
    idle(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
